jtag_tap_slave: RTL and testbench
=================================

JTAG_TAP_SLAVE -- requirements
Module: jtag_tap_slave

Interface
REQ-001 SHALL have parameter IR_LEN, default 4, instruction register width (>=2).
REQ-002 SHALL have parameter DR_LEN, default 32, USER data register width (>=2).
REQ-003 SHALL have parameter IDCODE, default 32'h1BA0_0477, value captured by the IDCODE instruction (bit0 must be 1).
REQ-004 SHALL have parameter USER_IR, default 4'h8, opcode selecting the USER data register.
REQ-005 SHALL have port CLK  input  1  single system clock; all logic on its posedge.
REQ-006 SHALL have port RESETn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port TCK  input  1  JTAG clock, asynchronous to CLK, oversampled.
REQ-008 SHALL have port TMS  input  1  JTAG mode select, asynchronous.
REQ-009 SHALL have port TDI  input  1  JTAG serial data in, asynchronous.
REQ-010 SHALL have port TDO  output  1  JTAG serial data out.
REQ-011 SHALL have port TDO_OE  output  1  high while TDO is valid (SHIFT_DR/SHIFT_IR).
REQ-012 SHALL have port DR_CAPTURE  input  DR_LEN  parallel value loaded into USER DR at capture.
REQ-013 SHALL have port DR_UPDATE  output  DR_LEN  USER DR value latched at update.
REQ-014 SHALL have port CAPTURE_STB  output  1  one-CLK pulse on entering CAPTURE_DR with USER selected.
REQ-015 SHALL have port UPDATE_STB  output  1  one-CLK pulse when DR_UPDATE is written.
REQ-016 SHALL have port STATE  output  4  current TAP state code.

Function
REQ-017 TCK, TMS, TDI SHALL each pass through a 2-flop synchronizer; TCK edges detected by comparing synchronized TCK with a third registered copy.
REQ-018 TCK high and low phases SHALL each be >=4 CLK periods; behaviour outside this is unspecified.
REQ-019 On a detected TCK rise, the TAP FSM SHALL advance per IEEE 1149.1 using synchronized TMS; STATE updates in the same CLK cycle.
REQ-020 STATE codes SHALL be: TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D.
REQ-021 TMS=1 for 5 consecutive TCK rises SHALL reach TLR from any state.
REQ-022 Rise in CAP_IR SHALL load IR shift register with {0..., 2'b01}; rise in CAP_DR SHALL load selected DR: USER <- DR_CAPTURE, IDCODE <- IDCODE, BYPASS <- 0.
REQ-023 Rise in SH_IR/SH_DR SHALL shift selected register right, TDI into MSB; BYPASS is 1 bit.
REQ-024 On detected TCK fall, TDO SHALL take selected shift register bit0 and TDO_OE SHALL be 1 if state is SH_IR/SH_DR, else TDO=0, TDO_OE=0; TDO holds between falls.
REQ-025 On detected TCK fall in UPD_IR, active IR SHALL load the IR shift register.
REQ-026 On detected TCK fall in UPD_DR with IR==USER_IR, DR_UPDATE SHALL load USER shift register and UPDATE_STB pulse that CLK.
REQ-027 CAPTURE_STB SHALL pulse the CLK STATE becomes CAP_DR with IR==USER_IR; DR_CAPTURE is sampled at the following TCK rise.
REQ-028 Opcodes other than USER_IR and IDCODE-opcode (4'h1, zero-extended) SHALL select BYPASS; all-ones SHALL select BYPASS.
REQ-029 While in TLR, active IR SHALL be forced every CLK to reset instruction (REQ-032/033).

Reset
REQ-030 RESETn low at a CLK posedge SHALL set STATE=TLR, TDO=0, TDO_OE=0, DR_UPDATE=0, CAPTURE_STB=0, UPDATE_STB=0, shift registers 0, synchronizers to TCK=0/TMS=1/TDI=0.
REQ-031 Reset mid-shift SHALL abort without UPDATE_STB; first TCK rise after release is evaluated from TLR.

Configuration
REQ-032 With JTAG_TAP_IDCODE_EN defined, opcode 4'h1 SHALL select 32-bit IDCODE register and reset instruction SHALL be IDCODE.
REQ-033 Without JTAG_TAP_IDCODE_EN, no IDCODE register SHALL exist, 4'h1 SHALL select BYPASS, reset instruction SHALL be BYPASS.

Verification
REQ-034 Reset, 5 TMS=1 clocks, TMS=0 -> STATE=C; shift 32 DR bits -> TDO stream 32'h1BA0_0477 LSB first (IDCODE_EN) or single 0 then TDI echo delayed 1 (no macro).
REQ-035 Shift IR 4'h8, TDO during IR shift = 4'b0001 LSB first -> IR=8 after UPD_IR.
REQ-036 IR=8, DR_CAPTURE=32'hDEAD_BEEF, shift in 32'h1234_5678 -> TDO out 32'hDEAD_BEEF, CAPTURE_STB 1 pulse, DR_UPDATE=32'h1234_5678 with 1 UPDATE_STB pulse.
REQ-037 IR=8, path CAP_DR->EX1_DR->PAU_DR->EX2_DR->SH_DR->UPD_DR with 8 bits -> no extra capture, exactly one UPDATE_STB.
REQ-038 IR=4'hF, shift 8'hA5 -> TDO equals TDI delayed one TCK.
REQ-039 RESETn asserted during SH_DR after 10 bits -> STATE=F, no UPDATE_STB, DR_UPDATE unchanged from 0.

Source files
------------

// File: rtl/jtag_tap_slave.sv
// IEEE 1149.1 TAP slave running entirely on the system clock, with TCK/TMS/TDI oversampled.
// Define JTAG_TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module jtag_tap_slave #(
    parameter int                IR_LEN  = 4,
    parameter int                DR_LEN  = 32,
    parameter logic [31:0]       IDCODE  = 32'h1BA0_0477,
    parameter logic [IR_LEN-1:0] USER_IR = IR_LEN'(4'h8)
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              TCK,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    output logic              TDO_OE,
    input  logic [DR_LEN-1:0] DR_CAPTURE,
    output logic [DR_LEN-1:0] DR_UPDATE,
    output logic              CAPTURE_STB,
    output logic              UPDATE_STB,
    output logic [3:0]        STATE
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_USER, SEL_IDCODE} dr_sel_e;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] IDCODE_OP = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] RESET_IR  = IDCODE_OP;
`else
    localparam logic [IR_LEN-1:0] RESET_IR  = '1;
`endif

    if (IR_LEN < 2 || DR_LEN < 2 || IDCODE[0] != 1'b1) begin : g_param_check
        $error("jtag_tap_slave: IR_LEN/DR_LEN must be >= 2 and IDCODE[0] must be 1");
    end

    logic tck_s1, tck_s2, tck_s3;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic tck_rise, tck_fall;

    tap_state_e state_q, state_d;
    dr_sel_e    dr_sel;

    logic [IR_LEN-1:0] ir_q;
    logic [IR_LEN-1:0] ir_shift;
    logic [DR_LEN-1:0] user_shift;
    logic              bypass_reg;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0]       idcode_shift;
`endif
    logic              tdo_bit;

    // NOTE: every register here resets synchronously and all sequential state uses non-blocking assignments.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            {tck_s1, tck_s2, tck_s3} <= 3'b000;
            {tms_s1, tms_s2}         <= 2'b11;
            {tdi_s1, tdi_s2}         <= 2'b00;
        end else begin
            {tck_s1, tck_s2, tck_s3} <= {TCK, tck_s1, tck_s2};
            {tms_s1, tms_s2}         <= {TMS, tms_s1};
            {tdi_s1, tdi_s2}         <= {TDI, tdi_s1};
        end
    end

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 & tck_s3;

    always_ff @(posedge CLK) begin
        if (!RESETn)
            state_q <= TLR;
        else
            state_q <= state_d;
    end

    // NOTE: defaults first so no path through this block leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s2 ? TLR    : RTI;
                RTI:     state_d = tms_s2 ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s2 ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s2 ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s2 ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s2 ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = tms_s2 ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = tms_s2 ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s2 ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s2 ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s2 ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s2 ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s2 ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = tms_s2 ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = tms_s2 ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s2 ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    assign STATE = state_q;

    // An all-ones opcode always means BYPASS, even if USER_IR was parameterised to it.
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir_q == USER_IR && ir_q != '1)
            dr_sel = SEL_USER;
`ifdef JTAG_TAP_IDCODE_EN
        else if (ir_q == IDCODE_OP)
            dr_sel = SEL_IDCODE;
`endif
    end

    always_comb begin
        tdo_bit = 1'b0;
        if (state_q == SH_IR) begin
            tdo_bit = ir_shift[0];
        end else begin
            case (dr_sel)
                SEL_USER:   tdo_bit = user_shift[0];
`ifdef JTAG_TAP_IDCODE_EN
                SEL_IDCODE: tdo_bit = idcode_shift[0];
`endif
                default:    tdo_bit = bypass_reg;
            endcase
        end
    end

    // Capture and shift act on the state being left at the TCK rise.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            ir_shift     <= '0;
            user_shift   <= '0;
            bypass_reg   <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_shift <= '0;
`endif
        end else if (tck_rise) begin
            case (state_q)
                CAP_IR: ir_shift <= IR_LEN'(2'b01);
                SH_IR:  ir_shift <= {tdi_s2, ir_shift[IR_LEN-1:1]};
                CAP_DR: begin
                    case (dr_sel)
                        SEL_USER:   user_shift   <= DR_CAPTURE;
`ifdef JTAG_TAP_IDCODE_EN
                        SEL_IDCODE: idcode_shift <= IDCODE;
`endif
                        default:    bypass_reg   <= 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (dr_sel)
                        SEL_USER:   user_shift   <= {tdi_s2, user_shift[DR_LEN-1:1]};
`ifdef JTAG_TAP_IDCODE_EN
                        SEL_IDCODE: idcode_shift <= {tdi_s2, idcode_shift[31:1]};
`endif
                        default:    bypass_reg   <= tdi_s2;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            TDO         <= 1'b0;
            TDO_OE      <= 1'b0;
            DR_UPDATE   <= '0;
            CAPTURE_STB <= 1'b0;
            UPDATE_STB  <= 1'b0;
            ir_q        <= RESET_IR;
        end else begin
            CAPTURE_STB <= tck_rise && (state_d == CAP_DR) && (dr_sel == SEL_USER);
            UPDATE_STB  <= 1'b0;
            if (tck_fall) begin
                if (state_q == SH_IR || state_q == SH_DR) begin
                    TDO    <= tdo_bit;
                    TDO_OE <= 1'b1;
                end else begin
                    TDO    <= 1'b0;
                    TDO_OE <= 1'b0;
                end
                if (state_q == UPD_IR)
                    ir_q <= ir_shift;
                if (state_q == UPD_DR && dr_sel == SEL_USER) begin
                    DR_UPDATE  <= user_shift;
                    UPDATE_STB <= 1'b1;
                end
            end
            // Test-Logic-Reset holds the reset instruction regardless of TCK activity.
            if (state_q == TLR)
                ir_q <= RESET_IR;
        end
    end

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Directed bench for jtag_tap_slave: TAP state walk table plus IR/DR shift, pause-path and reset-abort sequences.
module tb_jtag_tap_slave;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        TCK, TMS, TDI;
    logic        TDO, TDO_OE;
    logic [31:0] DR_CAPTURE;
    logic [31:0] DR_UPDATE;
    logic        CAPTURE_STB, UPDATE_STB;
    logic [3:0]  STATE;

    jtag_tap_slave dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .TCK         (TCK),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO         (TDO),
        .TDO_OE      (TDO_OE),
        .DR_CAPTURE  (DR_CAPTURE),
        .DR_UPDATE   (DR_UPDATE),
        .CAPTURE_STB (CAPTURE_STB),
        .UPDATE_STB  (UPDATE_STB),
        .STATE       (STATE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;

    // Strobe counters: a pulse stretched beyond one CLK counts more than once.
    always @(negedge CLK) begin
        if (CAPTURE_STB === 1'b1) cap_cnt++;
        if (UPDATE_STB === 1'b1) upd_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One TCK period: TMS/TDI set while TCK low, TDO/TDO_OE sampled just before the rise.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic oe);
        TMS = tms;
        TDI = tdi;
        repeat (3) @(negedge CLK);
        tdo = TDO;
        oe  = TDO_OE;
        TCK = 1'b1;
        repeat (6) @(negedge CLK);
        TCK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic step(input logic tms);
        logic d0, d1;
        tck_cycle(tms, 1'b0, d0, d1);
    endtask

    task automatic goto_rti();
        repeat (5) step(1'b1);
        step(1'b0);
    endtask

    // RTI -> SH_IR -> shift 4 bits -> UPD_IR -> RTI
    task automatic shift_ir(input logic [3:0] val, output logic [3:0] tdo_bits);
        logic b, oe;
        tdo_bits = '0;
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, val[i], b, oe);
            tdo_bits[i] = b;
        end
        step(1'b1); step(1'b0);
    endtask

    // RTI -> SH_DR -> shift n bits -> UPD_DR -> RTI
    task automatic shift_dr(input int n, input logic [31:0] din,
                            output logic [31:0] dout, output logic [31:0] oes);
        logic b, oe;
        dout = '0;
        oes  = '0;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b, oe);
            dout[i] = b;
            oes[i]  = oe;
        end
        step(1'b1); step(1'b0);
    endtask

    typedef struct {
        logic       tms;
        logic [3:0] exp_state;
    } walk_vec_t;

    walk_vec_t walk[25];

    initial begin
        logic [31:0] dout, oes;
        logic [3:0]  irout;
        int          c0, u0;
        logic        b, oe;

        walk[0]  = '{1'b1, 4'hF};  walk[1]  = '{1'b0, 4'hC};  walk[2]  = '{1'b0, 4'hC};
        walk[3]  = '{1'b1, 4'h7};  walk[4]  = '{1'b0, 4'h6};  walk[5]  = '{1'b0, 4'h2};
        walk[6]  = '{1'b0, 4'h2};  walk[7]  = '{1'b1, 4'h1};  walk[8]  = '{1'b0, 4'h3};
        walk[9]  = '{1'b0, 4'h3};  walk[10] = '{1'b1, 4'h0};  walk[11] = '{1'b0, 4'h2};
        walk[12] = '{1'b1, 4'h1};  walk[13] = '{1'b1, 4'h5};  walk[14] = '{1'b1, 4'h7};
        walk[15] = '{1'b1, 4'h4};  walk[16] = '{1'b0, 4'hE};  walk[17] = '{1'b0, 4'hA};
        walk[18] = '{1'b1, 4'h9};  walk[19] = '{1'b0, 4'hB};  walk[20] = '{1'b1, 4'h8};
        walk[21] = '{1'b1, 4'hD};  walk[22] = '{1'b1, 4'h7};  walk[23] = '{1'b1, 4'h4};
        walk[24] = '{1'b1, 4'hF};

        RESETn = 1'b0; TCK = 1'b0; TMS = 1'b1; TDI = 1'b0; DR_CAPTURE = '0;
        repeat (4) @(negedge CLK);
        check("rst_state", STATE, 4'hF);
        check("rst_tdo", TDO, 1'b0);
        check("rst_tdo_oe", TDO_OE, 1'b0);
        check("rst_dr_update", DR_UPDATE, 32'h0);
        check("rst_capture_stb", CAPTURE_STB, 1'b0);
        check("rst_update_stb", UPDATE_STB, 1'b0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset instruction selects a non-USER register, so the walk must raise no strobes.
        foreach (walk[i]) begin
            step(walk[i].tms);
            check($sformatf("walk%0d_state", i), STATE, walk[i].exp_state);
        end
        check("walk_no_capture_stb", cap_cnt, 0);
        check("walk_no_update_stb", upd_cnt, 0);

        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        check("to_sh_dr", STATE, 4'h2);
        repeat (5) step(1'b1);
        check("five_tms_to_tlr", STATE, 4'hF);

        // Reset abort mid-shift, with USER selected and DR_UPDATE still 0.
        goto_rti();
        shift_ir(4'h8, irout);
        DR_CAPTURE = 32'hFFFF_0000;
        u0 = upd_cnt;
        step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < 10; i++) tck_cycle(1'b0, i[0], b, oe);
        check("abort_in_sh_dr", STATE, 4'h2);
        RESETn = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_state", STATE, 4'hF);
        check("abort_tdo_oe", TDO_OE, 1'b0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        check("abort_dr_update", DR_UPDATE, 32'h0);
        check("abort_no_update_stb", upd_cnt - u0, 0);
        step(1'b0);
        check("abort_first_rise_from_tlr", STATE, 4'hC);

        // Default-register DR scan right after reset.
        goto_rti();
        check("rti_after_goto", STATE, 4'hC);
        shift_dr(32, 32'hCAFE_F00D, dout, oes);
`ifdef JTAG_TAP_IDCODE_EN
        check("idcode_stream", dout, 32'h1BA0_0477);
`else
        check("bypass_stream", dout, 32'h95FD_E01A);
`endif
        check("dr_shift_tdo_oe", oes, 32'hFFFF_FFFF);
        check("rti_tdo_oe_low", TDO_OE, 1'b0);

        shift_ir(4'h8, irout);
        check("ir_capture_pattern", irout, 4'b0001);

        DR_CAPTURE = 32'hDEAD_BEEF;
        c0 = cap_cnt; u0 = upd_cnt;
        shift_dr(32, 32'h1234_5678, dout, oes);
        check("user_capture_out", dout, 32'hDEAD_BEEF);
        check("user_dr_update", DR_UPDATE, 32'h1234_5678);
        check("user_capture_stb_once", cap_cnt - c0, 1);
        check("user_update_stb_once", upd_cnt - u0, 1);

        // Capture, detour through pause, resume shifting 8 bits.
        c0 = cap_cnt; u0 = upd_cnt;
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        check("pause_dr_state", STATE, 4'h3);
        step(1'b1); step(1'b0);
        check("resume_sh_dr", STATE, 4'h2);
        dout = '0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'h5A;
            tck_cycle(i == 7, pat[i], b, oe);
            dout[i] = b;
        end
        step(1'b1); step(1'b0);
        check("pause_path_tdo", dout, 32'h0000_00EF);
        check("pause_path_dr_update", DR_UPDATE, 32'h5ADE_ADBE);
        check("pause_path_capture_stb", cap_cnt - c0, 1);
        check("pause_path_update_stb", upd_cnt - u0, 1);

        // All-ones opcode: 1-bit bypass, TDO is TDI delayed one TCK.
        shift_ir(4'hF, irout);
        check("ir_capture_pattern_2", irout, 4'b0001);
        c0 = cap_cnt; u0 = upd_cnt;
        shift_dr(9, 32'h0000_00A5, dout, oes);
        check("bypass_echo", dout, 32'h0000_014A);
        check("bypass_no_capture_stb", cap_cnt - c0, 0);
        check("bypass_no_update_stb", upd_cnt - u0, 0);
        check("bypass_dr_update_held", DR_UPDATE, 32'h5ADE_ADBE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
